// File: rtl/eco32f_pkg.sv
// Shared constants, writeback source encoding and round-robin helper for the eco32f writeback stage.
package eco32f_pkg;

    localparam int unsigned ECO32F_DW      = 32;
    localparam int unsigned ECO32F_AW      = 5;
    localparam int unsigned ECO32F_EXC_REG = 30;
    localparam int unsigned RR_MAX_PORTS   = 32;

    typedef enum logic {
        WB_SRC_PIPE = 1'b0,
        WB_SRC_LL   = 1'b1
    } wb_src_e;

    // First set bit of req at or after ptr, wrapping at n; returns n when nothing is requesting.
    function automatic int unsigned rr_select(
        input logic [RR_MAX_PORTS-1:0] req,
        input int unsigned             ptr,
        input int unsigned             n
    );
        int unsigned idx;
        logic        found;
        rr_select = n;
        found     = 1'b0;
        for (int unsigned k = 0; k < RR_MAX_PORTS; k++) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (k < n && !found && req[idx[4:0]]) begin
                rr_select = idx;
                found     = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/eco32f_wb_fifo.sv
// Small synchronous completion FIFO; head is the oldest entry, valid whenever not empty.
module eco32f_wb_fifo #(
    parameter int unsigned WIDTH = 37,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_d  = wr_q + PW'(do_push);
        rd_d  = rd_q + PW'(do_pop);
        cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/eco32f_writeback_ll.sv
// Writeback stage: registers the memory-stage result and shares the register-file write port
// with long-latency completion FIFOs, tracking outstanding long-latency destinations.
module eco32f_writeback_ll
    import eco32f_pkg::*;
#(
    parameter int unsigned DW       = ECO32F_DW,
    parameter int unsigned AW       = ECO32F_AW,
    parameter int unsigned NUM_LL   = 2,
    parameter int unsigned LL_DEPTH = 2,
    parameter int unsigned EXC_REG  = ECO32F_EXC_REG
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 do_exception,
    input  logic                 mem_stall,
    input  logic [DW-1:0]        mem_pc,
    input  logic [DW-1:0]        mem_alu_result,
    input  logic [DW-1:0]        mem_lsu_result,
    input  logic                 mem_op_load,
    input  logic                 mem_rf_r_we,
    input  logic [AW-1:0]        mem_rf_r_addr,
    input  logic [NUM_LL-1:0]    ll_issue_valid,
    input  logic [NUM_LL*AW-1:0] ll_issue_addr,
    input  logic [NUM_LL-1:0]    ll_res_valid,
    output logic [NUM_LL-1:0]    ll_res_ready,
    input  logic [NUM_LL*DW-1:0] ll_res_data,
    input  logic [NUM_LL*AW-1:0] ll_res_addr,
    output logic [DW-1:0]        wb_rf_r,
    output logic                 wb_rf_r_we,
    output logic [AW-1:0]        wb_rf_r_addr,
    output logic [2**AW-1:0]     wb_pending
);

    localparam int unsigned RRW = (NUM_LL > 1) ? $clog2(NUM_LL) : 1;

    logic                    pipe_vld_q;
    logic [DW-1:0]           pipe_data_q;
    logic [AW-1:0]           pipe_addr_q;
    logic [RRW-1:0]          rr_q, rr_d;
    logic [2**AW-1:0]        pending_q, pending_d;

    logic [NUM_LL-1:0]       fifo_full, fifo_empty, fifo_pop;
    logic [DW+AW-1:0]        fifo_head [NUM_LL];
    logic [RR_MAX_PORTS-1:0] req;
    int unsigned             win;
    wb_src_e                 src;
    logic [DW-1:0]           ll_data;
    logic [AW-1:0]           ll_addr;

    for (genvar g = 0; g < NUM_LL; g++) begin : g_ll
        eco32f_wb_fifo #(
            .WIDTH(DW + AW),
            .DEPTH(LL_DEPTH)
        ) u_fifo (
            .clk    (clk),
            .rst    (rst),
            .push_i (ll_res_valid[g] & ~fifo_full[g]),
            .pop_i  (fifo_pop[g]),
            .data_i ({ll_res_data[g*DW +: DW], ll_res_addr[g*AW +: AW]}),
            .full_o (fifo_full[g]),
            .empty_o(fifo_empty[g]),
            .head_o (fifo_head[g])
        );
    end

    assign ll_res_ready = ~fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q  <= 1'b0;
            pipe_data_q <= '0;
            pipe_addr_q <= '0;
            rr_q        <= '0;
            pending_q   <= '0;
        end else begin
            pipe_vld_q <= ~mem_stall & (mem_rf_r_we | do_exception);
            if (!mem_stall) begin
                pipe_data_q <= do_exception ? mem_pc :
                               mem_op_load  ? mem_lsu_result : mem_alu_result;
                pipe_addr_q <= do_exception ? AW'(EXC_REG) : mem_rf_r_addr;
            end
            rr_q      <= rr_d;
            pending_q <= pending_d;
        end
    end

    // A valid pipe slot always owns the write port; FIFOs only drain in its bubbles.
    always_comb begin
        req             = '0;
        req[NUM_LL-1:0] = ~fifo_empty;
        win             = rr_select(req, 32'(rr_q), NUM_LL);
        src             = WB_SRC_PIPE;
        fifo_pop        = '0;
        rr_d            = rr_q;
        ll_data         = '0;
        ll_addr         = '0;
        if (!pipe_vld_q && win < NUM_LL) begin
            src = WB_SRC_LL;
            for (int unsigned i = 0; i < NUM_LL; i++) begin
                if (win == i) begin
                    fifo_pop[i] = 1'b1;
                    ll_data     = fifo_head[i][AW +: DW];
                    ll_addr     = fifo_head[i][AW-1:0];
                    rr_d        = (i == NUM_LL - 1) ? '0 : RRW'(i + 1);
                end
            end
        end
    end

    assign wb_rf_r_we   = pipe_vld_q | (src == WB_SRC_LL);
    assign wb_rf_r      = (src == WB_SRC_LL) ? ll_data : pipe_data_q;
    assign wb_rf_r_addr = (src == WB_SRC_LL) ? ll_addr : pipe_addr_q;

    // Clear first so a same-cycle issue to the popped register keeps the bit set.
    always_comb begin
        pending_d = pending_q;
        if (src == WB_SRC_LL) pending_d[ll_addr] = 1'b0;
        for (int unsigned i = 0; i < NUM_LL; i++) begin
            if (ll_issue_valid[i] && ll_issue_addr[i*AW +: AW] != '0)
                pending_d[ll_issue_addr[i*AW +: AW]] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    assign wb_pending = pending_q;

endmodule

// File: doc/eco32f_writeback_ll.md
# eco32f_writeback_ll

Parametrised writeback stage for the eco32f pipeline with long-latency result merging. It registers the memory-stage result, redirecting to the exception register on `do_exception`, and shares the single register-file write port with NUM_LL long-latency units (mul, div, …). Each long-latency unit has a small completion FIFO. A destination scoreboard tells issue logic which registers still await a long-latency result.

## Interface
- DW, 32, datapath width
- AW, 5, register address width
- NUM_LL, 2, number of long-latency result ports
- LL_DEPTH, 2, per-port completion FIFO depth (power of two, ≥2)
- EXC_REG, 30, register written with PC on exception
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- do_exception  in  1  exception taken at memory stage
- mem_stall  in  1  memory stage stalled
- mem_pc  in  DW  memory-stage PC
- mem_alu_result  in  DW  ALU result
- mem_lsu_result  in  DW  load data
- mem_op_load  in  1  memory-stage op is a load
- mem_rf_r_we  in  1  memory-stage op writes a register
- mem_rf_r_addr  in  AW  destination register
- ll_issue_valid  in  NUM_LL  long-latency op issued on port i this cycle
- ll_issue_addr  in  NUM_LL*AW  its destination register
- ll_res_valid  in  NUM_LL  result offered on port i
- ll_res_ready  out  NUM_LL  port i FIFO not full
- ll_res_data  in  NUM_LL*DW  result data
- ll_res_addr  in  NUM_LL*AW  result destination
- wb_rf_r  out  DW  register-file write data
- wb_rf_r_we  out  1  register-file write enable
- wb_rf_r_addr  out  AW  register-file write address
- wb_pending  out  2**AW  scoreboard, bit r set = r awaits a long-latency result

## Operation
- Pipe slot, loaded each edge:
  - pipe_vld <= !mem_stall & (mem_rf_r_we | do_exception).
  - Data/address load only when !mem_stall.
  - Data priority: do_exception→mem_pc; else mem_op_load→mem_lsu_result; else mem_alu_result.
  - Address: EXC_REG if do_exception, else mem_rf_r_addr.
- A stalled memory stage produces no repeated writes, so the write port is free for long-latency results.
- LL FIFO i:
  - Push on ll_res_valid[i] & ll_res_ready[i], capturing {data, addr}.
  - ll_res_ready[i] = !full_i (combinational).
- Write-port arbitration, combinational from registered state:
  - pipe_vld=1: the pipe slot writes and no FIFO pops.
  - Otherwise: round-robin among non-empty FIFOs, starting at rr_ptr. The winner's head drives wb_rf_r/addr with we=1, and the FIFO pops. rr_ptr <= winner+1 (mod NUM_LL).
  - No candidate: wb_rf_r_we=0; data/addr are don't-care and held at the last pipe values.
- Scoreboard:
  - ll_issue_valid[i] with addr≠0 sets the bit.
  - An LL writeback (pop) clears bit addr.
  - Set and clear of the same bit in one cycle: set wins.
  - Multiple issues in one cycle: all set.
  - Bit 0 is always 0.
- Pipe writes never touch the scoreboard. WAW against a pending register is prevented by issue logic and not checked here.
- do_exception does not flush FIFOs or the scoreboard; queued LL results are older than the excepting instruction and commit.

## Timing
- Pipe result: memory-stage values at edge N appear on wb_rf_r* during cycle N (after edge N) until edge N+1. This is a single write.
- LL result accepted at edge N: earliest write is cycle N (after the edge), same cycle as a pipe write would be. Its wb_pending bit clears at edge N+1.
- Full FIFO: ready=0, and valid must be held by the producer. A pop and push in the same cycle on a full FIFO is not allowed (ready is from the registered full flag).
- Starvation: bounded by continuous pipe writes only. With pipe idle, each non-empty port is served within NUM_LL cycles.
- Reset (async, any time): pipe_vld=0, wb_rf_r=0, wb_rf_r_addr=0, wb_rf_r_we=0, FIFOs empty (ll_res_ready all 1), wb_pending=0, rr_ptr=0. In-flight LL data is discarded.

## Structure
- eco32f_pkg holds:
  - default DW/AW/EXC_REG constants;
  - the writeback source-select encoding (PIPE, LL);
  - a helper function for round-robin index selection.
- Sub-module eco32f_wb_fifo: synchronous FIFO, parameters WIDTH, DEPTH; ports push/pop/full/empty/head. Instantiated NUM_LL times with WIDTH=DW+AW.

## Test plan
- Reset, then mem_rf_r_we=1, addr=5, alu=0x1234, stall=0 → next cycle we=1, addr=5, data=0x1234; following cycle (no new op) we=0.
- do_exception=1, mem_pc=0xC0000010, mem_op_load=1 → we=1, addr=30, data=0xC0000010.
- mem_stall=1 for 3 cycles after a write → exactly one write cycle. LL port 0 result {0xAA, r7} queued during the stall writes in the next idle cycle.
- Both LL ports push simultaneously (r3=0x11, r4=0x22), pipe idle → r3 written, then r4 the next cycle. Repeat with rr_ptr=1 → r4 first.
- ll_issue on r9 → wb_pending[9]=1. The result for r9 pops in cycle N → bit clears at N+1. New issue of r9 in the same cycle as the pop → bit stays 1.
- Fill port 1 FIFO (LL_DEPTH pushes) with continuous pipe writes → ready[1]=0. Assert rst mid-stream → ready all 1, wb_pending=0, we=0 immediately.
